// File: rtl/seg_scan_controller_pkg.sv
// Shared definitions for the 7-segment scan controller: state codes, blank patterns and
// the active-low hex segment table ({g,f,e,d,c,b,a}).
package seg_scan_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StFetch = 2'd1;
    localparam state_t StBlank = 2'd2;
    localparam state_t StShow  = 2'd3;

    localparam logic [3:0] EnableOff = 4'hF;
    localparam logic [6:0] SegOff    = 7'h7F;

    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // One-hot-low anode pattern; digit 0 is the rightmost digit.
    function automatic logic [3:0] digit_enable(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Processor debug read port as seen by the display scan controller.
interface seg_scan_controller_if;

    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );

endinterface

// File: rtl/seg_scan_controller_hex_to_seg.sv
// Combinational 4-bit to active-low 7-segment decoder, shared by the display blocks.
module seg_scan_controller_hex_to_seg
    import seg_scan_controller_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_seg(nibble);
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Fetches a 16-bit word over the debug read port and scans its nibbles onto a 4-digit display.
// Define SEG_ZERO_BLANK_EN to suppress leading-zero digits (digit 0 always lit).
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter int unsigned DWELL_CYC   = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   sw,
    seg_scan_controller_if.master        rd,
    output logic [3:0]                   ENABLE,
    output logic [6:0]                   LEDOUT,
    output logic                         stale
);

    localparam logic [CNT_W-1:0] DwellLast   = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BlankLast   = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [15:0]       word_q, word_d;
    logic              stale_q, stale_d;
    logic              req_q, req_d;
    logic [2:0]        addr_q, addr_d;
    logic [3:0]        enable_q, enable_d;
    logic [6:0]        led_q, led_d;
    logic [3:0]        nibble;
    logic [6:0]        seg;
    logic              lit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        word_d  = word_q;
        stale_d = stale_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
                req_d   = 1'b1;
                addr_d  = sw;
                cnt_d   = '0;
            end
            StFetch: begin
                if (req_q && rd.rd_ack) begin
                    word_d  = rd.rd_data;
                    stale_d = 1'b0;
                    req_d   = 1'b0;
                    digit_d = 2'd0;
                    state_d = StBlank;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    // Abandon the fetch but keep showing the previous word.
                    req_d   = 1'b0;
                    stale_d = 1'b1;
                    digit_d = 2'd0;
                    state_d = StBlank;
                    cnt_d   = '0;
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DwellLast) begin
                    cnt_d = '0;
                    if (digit_q == 2'd3) begin
                        state_d = StFetch;
                        req_d   = 1'b1;
                        addr_d  = sw;
                    end else begin
                        digit_d = digit_q + 2'd1;
                        state_d = StBlank;
                    end
                end
            end
        endcase
    end

    assign nibble = word_q[{digit_d, 2'b00} +: 4];

    seg_scan_controller_hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg)
    );

`ifdef SEG_ZERO_BLANK_EN
    logic [3:0] higher_nz;
    always_comb begin
        higher_nz = {|word_q[15:12], |word_q[15:8], |word_q[15:4], 1'b1};
        lit       = higher_nz[digit_d];
    end
`else
    assign lit = 1'b1;
`endif

    // Outputs are computed from next-state so anodes and segments switch on the same edge.
    always_comb begin
        enable_d = EnableOff;
        led_d    = SegOff;
        if (state_d == StShow && lit) begin
            enable_d = digit_enable(digit_d);
            led_d    = seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            digit_q  <= 2'd0;
            word_q   <= 16'h0000;
            stale_q  <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= 3'd0;
            enable_q <= EnableOff;
            led_q    <= SegOff;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            word_q   <= word_d;
            stale_q  <= stale_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            enable_q <= enable_d;
            led_q    <= led_d;
        end
    end

    assign rd.rd_req  = req_q;
    assign rd.rd_addr = addr_q;
    assign ENABLE     = enable_q;
    assign LEDOUT     = led_q;
    assign stale      = stale_q;

    assert property (@(posedge clk) disable iff (reset) $countones(~ENABLE) <= 1);
    assert property (@(posedge clk) disable iff (reset) (ENABLE != EnableOff) |-> (state_q == StShow));

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized bench for seg_scan_controller against a phase-list model of one scan.
module tb_seg_scan_controller;

    localparam int unsigned Dwell   = 4;
    localparam int unsigned Blank   = 2;
    localparam int unsigned Timeout = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sw;
    logic [3:0]  ENABLE;
    logic [6:0]  LEDOUT;
    logic        stale;

    seg_scan_controller_if rd_bus ();

    seg_scan_controller #(
        .DWELL_CYC   (Dwell),
        .BLANK_CYC   (Blank),
        .TIMEOUT_CYC (Timeout),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw     (sw),
        .rd     (rd_bus),
        .ENABLE (ENABLE),
        .LEDOUT (LEDOUT),
        .stale  (stale)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_word;
    logic        m_stale;
    logic [2:0]  m_addr;
    int          k;
    int          abort_at;

    function automatic logic [6:0] want_seg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_enable"}, 16'(ENABLE), 16'h000F);
        check({tag, "_ledout"}, 16'(LEDOUT), 16'h007F);
        check({tag, "_rd_req"}, 16'(rd_bus.rd_req), 16'h0000);
        check({tag, "_rd_addr"}, 16'(rd_bus.rd_addr), 16'h0000);
        check({tag, "_stale"}, 16'(stale), 16'h0000);
    endtask

    // Called with reset asserted at a sample point; releases it and steps into FETCH.
    task automatic restart();
        rd_bus.rd_ack = 1'b0;
        m_word  = 16'h0000;
        m_stale = 1'b0;
        reset   = 1'b0;
        m_addr  = sw;
        check_reset_values("idle");
        step();
    endtask

    task automatic hit_reset();
        #3 reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        step();
        restart();
    endtask

    task automatic cyc(input logic [3:0] en, input logic [6:0] led, input logic req,
                       output bit ab);
        ab = 1'b0;
        if (k == abort_at) begin
            hit_reset();
            ab = 1'b1;
            return;
        end
        check("enable", 16'(ENABLE), 16'(en));
        check("ledout", 16'(LEDOUT), 16'(led));
        check("rd_req", 16'(rd_bus.rd_req), 16'(req));
        check("stale", 16'(stale), 16'(m_stale));
        check("rd_addr", 16'(rd_bus.rd_addr), 16'(m_addr));
        k++;
        if ($urandom_range(3) == 0) sw = 3'($urandom);
        step();
    endtask

    // One full scan starting at the first FETCH cycle; lat >= Timeout means no ack.
    task automatic scan(input int lat, input logic [15:0] data, input int abort);
        bit          ab;
        bit          hit;
        bit          lit;
        logic [3:0]  en;
        logic [6:0]  led;
        k        = 0;
        abort_at = abort;
        for (int i = 0; i < int'(Timeout); i++) begin
            hit = (i == lat);
            rd_bus.rd_ack  = hit;
            rd_bus.rd_data = hit ? data : 16'($urandom);
            cyc(4'hF, 7'h7F, 1'b1, ab);
            if (ab) return;
            if (hit) begin
                m_word  = data;
                m_stale = 1'b0;
                break;
            end
            if (i == int'(Timeout) - 1) m_stale = 1'b1;
        end
        for (int d = 0; d < 4; d++) begin
            lit = 1'b1;
`ifdef SEG_ZERO_BLANK_EN
            if (d != 0 && (m_word >> (4 * d)) == 16'h0000) lit = 1'b0;
`endif
            en  = lit ? ~(4'b0001 << d) : 4'hF;
            led = lit ? want_seg(4'(m_word >> (4 * d))) : 7'h7F;
            for (int b = 0; b < int'(Blank); b++) begin
                rd_bus.rd_ack  = 1'($urandom_range(1));
                rd_bus.rd_data = 16'($urandom);
                cyc(4'hF, 7'h7F, 1'b0, ab);
                if (ab) return;
            end
            for (int w = 0; w < int'(Dwell); w++) begin
                rd_bus.rd_ack  = 1'($urandom_range(1));
                rd_bus.rd_data = 16'($urandom);
                cyc(en, led, 1'b0, ab);
                if (ab) return;
            end
        end
        m_addr = sw;
    endtask

    initial begin
        logic [15:0] data;
        int          ab_pt;
        reset          = 1'b1;
        sw             = 3'd5;
        rd_bus.rd_ack  = 1'b0;
        rd_bus.rd_data = 16'h0000;
        repeat (2) step();
        check_reset_values("reset");
        restart();

        scan(1, 16'h1A2F, -1);
        scan(100, 16'hFFFF, -1);
        scan(0, 16'h0007, -1);
        scan(2, 16'h0000, -1);
        scan(2, 16'hBEEF, 18);

        for (int n = 0; n < 40; n++) begin
            data = 16'($urandom) >> (4 * $urandom_range(3));
            if ($urandom_range(7) == 0) data = 16'h0000;
            ab_pt = ($urandom_range(5) == 0) ? int'($urandom_range(45)) : -1;
            scan(int'($urandom_range(Timeout + 2)), data, ab_pt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
